// File: rtl/hc595_frame_rx_pkg.sv
// Shared types and constants for the 74HC595 frame receiver.
package hc595_frame_rx_pkg;

  localparam int LAYER_W    = 64;
  localparam int SEL_W      = 8;
  localparam int NUM_LAYERS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

  function automatic logic sel_is_onehot(input logic [SEL_W-1:0] sel);
    return (sel != '0) && ((sel & (sel - SEL_W'(1))) == '0);
  endfunction

  function automatic logic [2:0] sel_to_idx(input logic [SEL_W-1:0] sel);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < SEL_W; i++) begin
      if (sel[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/hc595_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input plus a history flop
// that turns the synchronized level into a single-cycle rising-edge strobe.
module hc595_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/hc595_frame_rx.sv
// Receives a 74HC595 serial stream (select byte + 64 column bits) and latches
// the column data into one of eight layer registers. Optional stats: HC595_RX_STATS_EN.
module hc595_frame_rx
  import hc595_frame_rx_pkg::*;
#(
  parameter int CHAIN_BITS  = 72,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               sclk_in,
  input  logic               rclk_in,
  input  logic               sdio_in,
  output logic [LAYER_W-1:0] layer_1,
  output logic [LAYER_W-1:0] layer_2,
  output logic [LAYER_W-1:0] layer_3,
  output logic [LAYER_W-1:0] layer_4,
  output logic [LAYER_W-1:0] layer_5,
  output logic [LAYER_W-1:0] layer_6,
  output logic [LAYER_W-1:0] layer_7,
  output logic [LAYER_W-1:0] layer_8,
  output logic [2:0]         layer_idx,
  output logic               frame_valid,
  output logic               sel_err,
  output logic               len_err,
  output logic               abort
`ifdef HC595_RX_STATS_EN
  ,
  output logic [15:0]        frame_cnt,
  output logic [15:0]        err_cnt
`endif
);

  localparam int              TMO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [6:0]      CHAIN_CNT = 7'(CHAIN_BITS);

  logic sclk_rise, rclk_rise, sdio_s;
  logic sclk_lvl_unused, rclk_lvl_unused, sdio_rise_unused;

  hc595_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk_i(clk_in), .rst_ni(rst_n_in), .d_i(sclk_in), .q_o(sclk_lvl_unused), .rise_o(sclk_rise)
  );
  hc595_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rclk (
    .clk_i(clk_in), .rst_ni(rst_n_in), .d_i(rclk_in), .q_o(rclk_lvl_unused), .rise_o(rclk_rise)
  );
  hc595_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdio (
    .clk_i(clk_in), .rst_ni(rst_n_in), .d_i(sdio_in), .q_o(sdio_s), .rise_o(sdio_rise_unused)
  );

  state_e                 state_q, state_d;
  logic [CHAIN_BITS-1:0]  shreg_q, shreg_d;
  logic [6:0]             cnt_q, cnt_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [SEL_W-1:0]       cap_sel_q, cap_sel_d;
  logic [LAYER_W-1:0]     cap_col_q, cap_col_d;
  logic [6:0]             cap_cnt_q, cap_cnt_d;
  logic                   abort_d;

  // rclk captures the register as it stood before any same-cycle shift, and the
  // coincident sclk bit becomes bit 1 of the following frame.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    tmo_d     = '0;
    cap_sel_d = cap_sel_q;
    cap_col_d = cap_col_q;
    cap_cnt_d = cap_cnt_q;
    abort_d   = 1'b0;

    if (sclk_rise) begin
      shreg_d = {shreg_q[CHAIN_BITS-2:0], sdio_s};
      cnt_d   = (cnt_q == 7'h7F) ? cnt_q : cnt_q + 7'd1;
    end

    unique case (state_q)
      ST_IDLE, ST_SHIFT: begin
        if (rclk_rise) begin
          cap_sel_d = shreg_q[CHAIN_BITS-1 -: SEL_W];
          cap_col_d = shreg_q[LAYER_W-1:0];
          cap_cnt_d = cnt_q;
          cnt_d     = sclk_rise ? 7'd1 : 7'd0;
          state_d   = ST_LATCH;
        end else if (state_q == ST_IDLE) begin
          if (sclk_rise) state_d = ST_SHIFT;
        end else if (!sclk_rise) begin
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_q == TMO_LAST) begin
            abort_d = 1'b1;
            cnt_d   = '0;
            tmo_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      ST_LATCH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      cap_sel_q <= '0;
      cap_col_q <= '0;
      cap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      cap_sel_q <= cap_sel_d;
      cap_col_q <= cap_col_d;
      cap_cnt_q <= cap_cnt_d;
    end
  end

  logic [LAYER_W-1:0] layer_q [NUM_LAYERS];
  logic [2:0]         idx_q;
  logic               fv_q, sel_err_q, len_err_q, abort_q;
  logic               sel_ok, len_ok;
  logic [2:0]         sel_idx;

  assign sel_ok  = sel_is_onehot(cap_sel_q);
  assign len_ok  = (cap_cnt_q == CHAIN_CNT);
  assign sel_idx = sel_to_idx(cap_sel_q);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NUM_LAYERS; i++) layer_q[i] <= '0;
      idx_q     <= '0;
      fv_q      <= 1'b0;
      sel_err_q <= 1'b0;
      len_err_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      fv_q      <= 1'b0;
      sel_err_q <= 1'b0;
      len_err_q <= 1'b0;
      abort_q   <= abort_d;
      if (state_q == ST_LATCH) begin
        sel_err_q <= !sel_ok;
        len_err_q <= !len_ok;
        if (sel_ok && len_ok) begin
          layer_q[sel_idx] <= cap_col_q;
          idx_q            <= sel_idx;
          fv_q             <= 1'b1;
        end
      end
    end
  end

  assign layer_1     = layer_q[0];
  assign layer_2     = layer_q[1];
  assign layer_3     = layer_q[2];
  assign layer_4     = layer_q[3];
  assign layer_5     = layer_q[4];
  assign layer_6     = layer_q[5];
  assign layer_7     = layer_q[6];
  assign layer_8     = layer_q[7];
  assign layer_idx   = idx_q;
  assign frame_valid = fv_q;
  assign sel_err     = sel_err_q;
  assign len_err     = len_err_q;
  assign abort       = abort_q;

`ifdef HC595_RX_STATS_EN
  logic [15:0] frame_cnt_q, err_cnt_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (fv_q && frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 16'd1;
      if ((sel_err_q || len_err_q || abort_q) && err_cnt_q != 16'hFFFF)
        err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: doc/hc595_frame_rx.md
HC595_FRAME_RX -- requirements
Module: hc595_frame_rx

Interface
REQ-001 Parameter CHAIN_BITS, default 72, SHALL set the serial bits per frame: 8 layer-select bits plus 64 column bits.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the input synchronizer depth; legal range 2..3.
REQ-003 Parameter TIMEOUT_CYC, default 4096, SHALL set the clk_in cycles without an sclk rise before a partial frame is aborted.
REQ-004 clk_in  input  1  system clock; all state on its rising edge.
REQ-005 rst_n_in  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 sclk_in  input  1  74HC595 shift clock (SH_CP), asynchronous to clk_in.
REQ-007 rclk_in  input  1  74HC595 storage clock (ST_CP), asynchronous to clk_in.
REQ-008 sdio_in  input  1  74HC595 serial data (DS), asynchronous to clk_in.
REQ-009 layer_1 .. layer_8  output  64 each  reconstructed per-layer column data.
REQ-010 layer_idx  output  3  index of the most recently latched layer (0 = layer_1).
REQ-011 frame_valid  output  1  one-cycle pulse on each accepted latch.
REQ-012 sel_err  output  1  one-cycle pulse: latched select byte not one-hot.
REQ-013 len_err  output  1  one-cycle pulse: bit count at latch was not CHAIN_BITS.
REQ-014 abort  output  1  one-cycle pulse: timeout discarded a partial frame.

Function
REQ-015 sclk_in, rclk_in and sdio_in SHALL each pass through SYNC_STAGES flops, followed by one history flop for rising-edge detection.
REQ-016 Each synchronized sclk rise SHALL shift the synchronized sdio into bit 0 of a CHAIN_BITS shift register; bits move toward the MSB.
REQ-017 After a full frame, bits [71:64] SHALL be the select byte (first 8 bits shifted), and bits [63:0] SHALL be column data.
REQ-018 The FSM SHALL have states IDLE, SHIFT and LATCH; IDLE->SHIFT on sclk rise; SHIFT->LATCH on rclk rise; LATCH->IDLE after one cycle.
REQ-019 A 7-bit bit counter SHALL increment on each sclk rise, saturate at 127, and clear on the LATCH state or on abort.
REQ-020 In LATCH with a one-hot select and count == CHAIN_BITS, the block SHALL write [63:0] to layer_(k+1), where bit k is set, set layer_idx = k and pulse frame_valid.
REQ-021 A select byte that is not one-hot (zero or multi-bit) SHALL pulse sel_err and update no layer register.
REQ-022 A count != CHAIN_BITS SHALL pulse len_err and update no layer register; sel_err SHALL also be evaluated and may pulse in the same cycle.
REQ-023 An rclk rise in IDLE SHALL be treated as a latch with count 0 and therefore pulse len_err.
REQ-024 When sclk and rclk rise in the same cycle, the latch SHALL capture the pre-shift contents, as the 74HC595 does; the new bit SHALL be counted as bit 1 of the next frame.
REQ-025 In SHIFT, TIMEOUT_CYC cycles without an sclk rise SHALL pulse abort, clear the counter and return to IDLE; the layer registers are not touched.
REQ-026 Detection latency SHALL be SYNC_STAGES+1 cycles from the input edge to the internal strobe; layer outputs SHALL update on the cycle after LATCH entry.

Reset
REQ-027 Assertion of rst_n_in SHALL asynchronously clear the FSM to IDLE and clear all synchronizers, the shift register, the counter, the timeout counter, layer_1..8, layer_idx and all pulse outputs to 0.
REQ-028 A reset in the middle of a frame SHALL discard that frame; the first rclk after reset with fewer than CHAIN_BITS shifts SHALL pulse len_err.

Configuration
REQ-029 Macro HC595_RX_STATS_EN defined: the block SHALL add outputs frame_cnt[15:0] and err_cnt[15:0], both saturating and reset to 0; frame_cnt counts frame_valid pulses and err_cnt counts cycles in which any of sel_err, len_err or abort is high.
REQ-030 Macro HC595_RX_STATS_EN absent: these ports and counters SHALL not exist, and all other behaviour SHALL be identical.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, LAYER_W=64, SEL_W=8 and NUM_LAYERS=8.
REQ-032 Sub-module hc595_sync_edge SHALL implement the synchronizer plus rising-edge detector and be instantiated three times.

Verification
REQ-033 Shift 72 bits of select 8'b0000_0100 with column 64'hA5A5_0000_FFFF_1234, then rclk -> layer_3 = 64'hA5A5_0000_FFFF_1234, layer_idx = 2, frame_valid pulses once.
REQ-034 Select 8'b0000_0011 with 72 bits -> sel_err pulses once and all layers stay unchanged.
REQ-035 Shift only 71 bits, then rclk -> len_err pulses, no layer is written, and the counter reads 0 afterwards.
REQ-036 Shift 30 bits, then idle for 4096 cycles -> abort pulses, FSM is IDLE, and a following full frame latches correctly.
REQ-037 Drive sclk and rclk rising together on bit 72 -> the latch holds the pre-shift content, the 71-bit count gives len_err, and the next frame count starts at 1.
REQ-038 Assert rst_n_in after 40 bits -> all outputs are 0 immediately (asynchronously); with HC595_RX_STATS_EN, 3 good frames give frame_cnt = 3 and err_cnt = 0.
